// File: rtl/if_stage_if.sv
// Instruction-memory request/acknowledge port of the fetch stage.
// master: the fetch stage drives request and address.
// slave: the memory returns the acknowledge and the instruction word.
interface if_stage_if;
    logic        imem_req_o;
    logic [15:0] imem_addr_o;
    logic        imem_ack_i;
    logic [15:0] imem_data_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_ack_i,
        input  imem_data_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_ack_i,
        output imem_data_i
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Holds the PC, fetches one word per req/ack handshake and presents
// {pc+1, instruction} to decode. A one-entry hold buffer absorbs decode
// stalls. Branch redirects from decode take effect after exactly one delay
// slot. While a fetch is outstanding the address stays frozen, so a branch
// that arrives then is parked in redir_pc until the delay-slot word lands.
module if_stage #(
    parameter logic [15:0] PC_RESET = 16'h0000,
    parameter logic [15:0] NOP_INST = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [15:0] branch_addr_i,
    if_stage_if.master  imem,
    output logic [15:0] pc_o,
    output logic [15:0] inst_o
);

    typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

    state_t      state_reg, state_next;
    logic        req_en_reg;
    logic [15:0] pc_reg, pc_next;
    logic        redir_valid_reg, redir_valid_next;
    logic [15:0] redir_pc_reg, redir_pc_next;
    logic [15:0] hold_pc_reg, hold_pc_next;
    logic [15:0] hold_inst_reg, hold_inst_next;
    logic [15:0] out_pc_reg, out_pc_next;
    logic [15:0] out_inst_reg, out_inst_next;

    logic        req;
    logic        fire;
    logic        branch_accept;
    logic [15:0] pc_inc;

    // Request is suppressed for the first cycle after reset release and while a word is parked.
    assign req           = (state_reg == FETCH) && req_en_reg;
    assign fire          = req && imem.imem_ack_i;
    assign branch_accept = branch_flag_i && !stall_i;
    assign pc_inc        = pc_reg + 16'd1;

    assign imem.imem_req_o  = req;
    assign imem.imem_addr_o = pc_reg;
    assign pc_o             = out_pc_reg;
    assign inst_o           = out_inst_reg;

    // Next-state logic: fetch sequencing, redirect bookkeeping and IF/ID update.
    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        redir_valid_next = redir_valid_reg;
        redir_pc_next    = redir_pc_reg;
        hold_pc_next     = hold_pc_reg;
        hold_inst_next   = hold_inst_reg;
        out_pc_next      = out_pc_reg;
        out_inst_next    = out_inst_reg;

        case (state_reg)
            FETCH: begin
                if (fire) begin
                    // The word just fetched is the delay slot of any pending or current branch.
                    if (redir_valid_reg) begin
                        pc_next = redir_pc_reg;
                    end else if (branch_accept) begin
                        pc_next = branch_addr_i;
                    end else begin
                        pc_next = pc_inc;
                    end
                    redir_valid_next = 1'b0;
                    if (stall_i) begin
                        hold_pc_next   = pc_inc;
                        hold_inst_next = imem.imem_data_i;
                        state_next     = HOLD;
                    end else begin
                        out_pc_next   = pc_inc;
                        out_inst_next = imem.imem_data_i;
                    end
                end else begin
                    // Address must stay stable mid-fetch, so the target waits in redir_pc.
                    if (branch_accept && !redir_valid_reg) begin
                        redir_pc_next    = branch_addr_i;
                        redir_valid_next = 1'b1;
                    end
                    if (!stall_i) begin
                        out_inst_next = NOP_INST;
                    end
                end
            end
            HOLD: begin
                if (!stall_i) begin
                    out_pc_next   = hold_pc_reg;
                    out_inst_next = hold_inst_reg;
                    state_next    = FETCH;
                    // Delay slot is already buffered, so the redirect applies at once.
                    if (branch_accept) begin
                        pc_next = branch_addr_i;
                    end
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= FETCH;
            req_en_reg      <= 1'b0;
            pc_reg          <= PC_RESET;
            redir_valid_reg <= 1'b0;
            redir_pc_reg    <= 16'h0000;
            hold_pc_reg     <= 16'h0000;
            hold_inst_reg   <= NOP_INST;
            out_pc_reg      <= 16'h0000;
            out_inst_reg    <= NOP_INST;
        end else begin
            state_reg       <= state_next;
            req_en_reg      <= 1'b1;
            pc_reg          <= pc_next;
            redir_valid_reg <= redir_valid_next;
            redir_pc_reg    <= redir_pc_next;
            hold_pc_reg     <= hold_pc_next;
            hold_inst_reg   <= hold_inst_next;
            out_pc_reg      <= out_pc_next;
            out_inst_reg    <= out_inst_next;
        end
    end

    // Decode never issues a second branch while a redirect is still parked.
    a_single_redirect: assert property (@(posedge clk) disable iff (!rst)
        !(branch_accept && redir_valid_reg));

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: reset/wrap checks, a directed vector
// table, a mid-fetch reset sequence and a randomized run against a
// transaction-level model of the fetch stream.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        br;
    logic [15:0] baddr;
    logic [15:0] pc_o, inst_o;
    logic [15:0] w_pc, w_inst;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        return 16'h4800 + a;
    endfunction

    if_stage_if bus();
    if_stage_if wbus();

    assign bus.imem_data_i  = mem_fn(bus.imem_addr_o);
    assign wbus.imem_data_i = mem_fn(wbus.imem_addr_o);
    assign wbus.imem_ack_i  = 1'b1;

    if_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall),
        .branch_flag_i (br),
        .branch_addr_i (baddr),
        .imem          (bus),
        .pc_o          (pc_o),
        .inst_o        (inst_o)
    );

    if_stage #(.PC_RESET(16'hFFFF)) dut_w (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (1'b0),
        .branch_flag_i (1'b0),
        .branch_addr_i (16'h0000),
        .imem          (wbus),
        .pc_o          (w_pc),
        .inst_o        (w_inst)
    );

    typedef struct {
        logic        stall;
        logic        br;
        logic [15:0] baddr;
        logic        ack;
        logic        req;
        logic [15:0] addr;
        logic [15:0] pc;
        logic [15:0] inst;
    } vec_t;

    localparam int NVEC = 25;
    vec_t tab [NVEC];

    function automatic vec_t mk(input logic s, input logic b, input logic [15:0] ba,
                                input logic a, input logic r, input logic [15:0] ad,
                                input logic [15:0] p, input logic [15:0] in);
        vec_t v;
        v.stall = s; v.br = b; v.baddr = ba; v.ack = a;
        v.req = r; v.addr = ad; v.pc = p; v.inst = in;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_main(input string tag, input logic r, input logic [15:0] ad,
                            input logic [15:0] p, input logic [15:0] in);
        chk({tag, ".req"},  {15'd0, bus.imem_req_o}, {15'd0, r});
        chk({tag, ".addr"}, bus.imem_addr_o, ad);
        chk({tag, ".pc"},   pc_o, p);
        chk({tag, ".inst"}, inst_o, in);
    endtask

    task automatic chk_wrap(input string tag, input logic r, input logic [15:0] ad,
                            input logic [15:0] p, input logic [15:0] in);
        chk({tag, ".req"},  {15'd0, wbus.imem_req_o}, {15'd0, r});
        chk({tag, ".addr"}, wbus.imem_addr_o, ad);
        chk({tag, ".pc"},   w_pc, p);
        chk({tag, ".inst"}, w_inst, in);
    endtask

    // Transaction-level reference: next fetch address, owed redirect, parked word, IF/ID view.
    logic        m_run, m_park, m_owed;
    logic [15:0] m_addr, m_owed_a, m_park_pc, m_park_inst, m_pc, m_inst;

    function automatic logic m_req();
        return m_run && !m_park;
    endfunction

    task automatic model_step(input logic s, input logic b, input logic [15:0] ba, input logic a);
        logic        take;
        logic [15:0] wpc, winst;
        take = b && !s;
        if (m_park) begin
            if (!s) begin
                m_pc   = m_park_pc;
                m_inst = m_park_inst;
                m_park = 1'b0;
                if (take) m_addr = ba;
            end
        end else if (m_req() && a) begin
            wpc   = m_addr + 16'd1;
            winst = mem_fn(m_addr);
            if (m_owed)     m_addr = m_owed_a;
            else if (take)  m_addr = ba;
            else            m_addr = wpc;
            m_owed = 1'b0;
            if (s) begin
                m_park = 1'b1; m_park_pc = wpc; m_park_inst = winst;
            end else begin
                m_pc = wpc; m_inst = winst;
            end
        end else begin
            if (take) begin
                m_owed = 1'b1; m_owed_a = ba;
            end
            if (!s) m_inst = 16'h0800;
        end
        m_run = 1'b1;
    endtask

    initial begin
        tab[0]  = mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0800);
        tab[1]  = mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0001, 16'h0001, 16'h4800);
        tab[2]  = mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0002, 16'h0002, 16'h4801);
        tab[3]  = mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0003, 16'h0003, 16'h4802);
        tab[4]  = mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0003, 16'h0003, 16'h0800);
        tab[5]  = mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0003, 16'h0003, 16'h0800);
        tab[6]  = mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0004, 16'h0004, 16'h4803);
        tab[7]  = mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0005, 16'h0005, 16'h4804);
        tab[8]  = mk(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0006, 16'h0005, 16'h4804);
        tab[9]  = mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0006, 16'h0005, 16'h4804);
        tab[10] = mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0006, 16'h0005, 16'h4804);
        tab[11] = mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0006, 16'h0005, 16'h4804);
        tab[12] = mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0006, 16'h0006, 16'h4805);
        tab[13] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0007, 16'h0007, 16'h4806);
        tab[14] = mk(1'b0, 1'b1, 16'h0040, 1'b0, 1'b1, 16'h0007, 16'h0007, 16'h0800);
        tab[15] = mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0007, 16'h0007, 16'h0800);
        tab[16] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0040, 16'h0008, 16'h4807);
        tab[17] = mk(1'b0, 1'b1, 16'h0020, 1'b1, 1'b1, 16'h0020, 16'h0041, 16'h4840);
        tab[18] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0021, 16'h0021, 16'h4820);
        tab[19] = mk(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0022, 16'h0021, 16'h4820);
        tab[20] = mk(1'b0, 1'b1, 16'h0030, 1'b0, 1'b1, 16'h0030, 16'h0022, 16'h4821);
        tab[21] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0031, 16'h0031, 16'h4830);
        tab[22] = mk(1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 16'hFFFF, 16'h0032, 16'h4831);
        tab[23] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h47FF);
        tab[24] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0001, 16'h0001, 16'h4800);

        rst = 1'b0; stall = 1'b0; br = 1'b0; baddr = 16'h0000; bus.imem_ack_i = 1'b0;

        // Reset values of both instances, then the PC_RESET=FFFF wrap sequence.
        @(negedge clk);
        chk_main("rst", 1'b0, 16'h0000, 16'h0000, 16'h0800);
        chk_wrap("wrst", 1'b0, 16'hFFFF, 16'h0000, 16'h0800);
        rst = 1'b1;
        cyc(); chk_wrap("wrap0", 1'b1, 16'hFFFF, 16'h0000, 16'h0800);
        cyc(); chk_wrap("wrap1", 1'b1, 16'h0000, 16'h0000, 16'h47FF);
        cyc(); chk_wrap("wrap2", 1'b1, 16'h0001, 16'h0001, 16'h4800);
        $display("wrap: pc_o=%h inst_o=%h", w_pc, w_inst);

        // Directed vector table from a fresh reset.
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            stall = tab[i].stall; br = tab[i].br; baddr = tab[i].baddr;
            bus.imem_ack_i = tab[i].ack;
            cyc();
            chk_main($sformatf("vec%0d", i), tab[i].req, tab[i].addr, tab[i].pc, tab[i].inst);
            $display("vec %0d: req=%b addr=%h pc_o=%h inst_o=%h", i,
                     bus.imem_req_o, bus.imem_addr_o, pc_o, inst_o);
        end
        stall = 1'b0; br = 1'b0; baddr = 16'h0000;

        // Asynchronous reset with a fetch outstanding; the late ack must be ignored.
        bus.imem_ack_i = 1'b0;
        #2 rst = 1'b0;
        #1 chk_main("arst", 1'b0, 16'h0000, 16'h0000, 16'h0800);
        @(negedge clk);
        bus.imem_ack_i = 1'b1;
        cyc(); chk_main("arst_ack", 1'b0, 16'h0000, 16'h0000, 16'h0800);
        rst = 1'b1;
        cyc(); chk_main("arst_rel", 1'b1, 16'h0000, 16'h0000, 16'h0800);
        cyc(); chk_main("arst_f0", 1'b1, 16'h0001, 16'h0001, 16'h4800);
        $display("arst: pc_o=%h inst_o=%h", pc_o, inst_o);

        // Randomized run against the reference model.
        bus.imem_ack_i = 1'b0;
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        m_run = 1'b0; m_park = 1'b0; m_owed = 1'b0;
        m_addr = 16'h0000; m_owed_a = 16'h0000; m_park_pc = 16'h0000; m_park_inst = 16'h0000;
        m_pc = 16'h0000; m_inst = 16'h0800;
        for (int n = 0; n < 600; n++) begin
            logic s, b, a;
            logic [15:0] ba;
            chk_main($sformatf("rnd%0d", n), m_req(), m_addr, m_pc, m_inst);
            s  = ($urandom_range(0, 3) == 0);
            b  = !m_owed && ($urandom_range(0, 4) == 0);
            ba = 16'($urandom);
            a  = m_req() && ($urandom_range(0, 2) != 0);
            stall = s; br = b; baddr = ba; bus.imem_ack_i = a;
            model_step(s, b, ba, a);
            cyc();
        end
        chk_main("rnd_end", m_req(), m_addr, m_pc, m_inst);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
